// File: rtl/rice_stream_packer.sv
// Rice codeword / header / raw-field bit packer for the frame output RAM.
// Bits are gathered MSB-first in a double-width accumulator and emitted as
// WORD_W-bit words through a single auto-incrementing RAM write port.
// Unary runs too long to fit in one cycle are streamed out over several
// cycles, and commands are throttled with a valid/ready handshake.
module rice_stream_packer #(
  parameter int WORD_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int PARAM_W = 4,
  parameter int Q_W     = 16,
  localparam int LEN_W  = $clog2(WORD_W)
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iValid,
  output logic               oReady,
  input  logic [1:0]         iKind,
  input  logic [Q_W-1:0]     iUpper,
  input  logic [WORD_W-2:0]  iLower,
  input  logic [LEN_W-1:0]   iLen,
  input  logic [PARAM_W-1:0] iRiceParam,
  output logic               oRamEnable,
  output logic [ADDR_W-1:0]  oRamAddress,
  output logic [WORD_W-1:0]  oRamData,
  output logic               oFlushDone,
  output logic [ADDR_W:0]    oWordCount
);

  localparam int ACC_W  = 2 * WORD_W;
  localparam int FILL_W = $clog2(ACC_W) + 1;
  localparam int SUM_W  = ((Q_W > FILL_W) ? Q_W : FILL_W) + 2;

  localparam logic [LEN_W-1:0]  K_MAX     = LEN_W'(WORD_W - 1);
  localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] FILL_ACC  = FILL_W'(ACC_W);
  localparam logic [FILL_W-1:0] FILL_ONE  = {{(FILL_W-1){1'b0}}, 1'b1};
  localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};
  localparam logic [SUM_W-1:0]  SUM_WORD  = SUM_W'(WORD_W);
  localparam logic [ACC_W-1:0]  ACC_ONE   = {{(ACC_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0]  ACC_ZERO  = {ACC_W{1'b0}};
  localparam logic [Q_W-1:0]    Q_ZERO    = {Q_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_MAX   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [WORD_W-1:0] WORD_ZERO = {WORD_W{1'b0}};

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_ZEROS  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  // OR a right-aligned field of len bits in directly below the fill point.
  function automatic logic [ACC_W-1:0] append_bits(
    input logic [ACC_W-1:0]  acc,
    input logic [FILL_W-1:0] fill,
    input logic [ACC_W-1:0]  val,
    input logic [FILL_W-1:0] len
  );
    logic [FILL_W-1:0] sh;
    sh = FILL_ACC - fill - len;
    return acc | (val << sh);
  endfunction

  // Keep only the low n bits of a field.
  function automatic logic [ACC_W-1:0] low_bits(
    input logic [WORD_W-2:0] v,
    input logic [LEN_W-1:0]  n
  );
    logic [ACC_W-1:0] mask;
    mask = (ACC_ONE << n) - ACC_ONE;
    return ACC_W'(v) & mask;
  endfunction

  // Stop bit followed by k low bits; leading unary zeros add no value bits.
  function automatic logic [ACC_W-1:0] code_val(
    input logic [WORD_W-2:0] v,
    input logic [LEN_W-1:0]  k
  );
    return (ACC_ONE << k) | low_bits(v, k);
  endfunction

  state_t              state_r, state_s;
  logic [ACC_W-1:0]    acc_r, acc_s;
  logic [FILL_W-1:0]   fill_r, fill_s;
  logic [Q_W-1:0]      zeros_r, zeros_s;
  logic [LEN_W-1:0]    k_r, k_s;
  logic [WORD_W-2:0]   low_r, low_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W:0]     count_r;
  logic                ready_r;
  logic                ram_en_r;
  logic [ADDR_W-1:0]   ram_addr_r;
  logic [WORD_W-1:0]   ram_data_r;
  logic                done_r;
  logic [ADDR_W:0]     word_count_r;

  logic [FILL_W-1:0]   app_len_s;
  logic [LEN_W-1:0]    k_in_s;
  logic                wr_en_s;
  logic [WORD_W-1:0]   wr_data_s;
  logic                done_s;

  assign k_in_s      = (iLen > K_MAX) ? K_MAX : iLen;
  assign oReady      = ready_r;
  assign oRamEnable  = ram_en_r;
  assign oRamAddress = ram_addr_r;
  assign oRamData    = ram_data_r;
  assign oFlushDone  = done_r;
  assign oWordCount  = word_count_r;

  // Next-state, accumulator update and word-emit decision for the packer.
  always_comb begin
    state_s   = state_r;
    acc_s     = acc_r;
    fill_s    = fill_r;
    zeros_s   = zeros_r;
    k_s       = k_r;
    low_s     = low_r;
    app_len_s = FILL_ZERO;
    wr_en_s   = 1'b0;
    wr_data_s = WORD_ZERO;
    done_s    = 1'b0;
    case (state_r)
      ST_ACCEPT: begin
        if (iValid && ready_r) begin
          case (iKind)
            2'd0: begin
              if ((SUM_W'(fill_r) + SUM_W'(iUpper)) < SUM_WORD) begin
                app_len_s = FILL_W'(iUpper) + FILL_ONE + FILL_W'(k_in_s);
                acc_s     = append_bits(acc_r, fill_r, code_val(iLower, k_in_s), app_len_s);
                fill_s    = fill_r + app_len_s;
                state_s   = (fill_s >= FILL_WORD) ? ST_DRAIN : ST_ACCEPT;
              end else begin
                zeros_s = iUpper;
                k_s     = k_in_s;
                low_s   = iLower;
                state_s = ST_ZEROS;
              end
            end
            2'd1: begin
              app_len_s = FILL_W'(PARAM_W);
              acc_s     = append_bits(acc_r, fill_r, ACC_W'(iRiceParam), app_len_s);
              fill_s    = fill_r + app_len_s;
              state_s   = (fill_s >= FILL_WORD) ? ST_DRAIN : ST_ACCEPT;
            end
            2'd2: begin
              app_len_s = FILL_W'(k_in_s);
              acc_s     = append_bits(acc_r, fill_r, low_bits(iLower, k_in_s), app_len_s);
              fill_s    = fill_r + app_len_s;
              state_s   = (fill_s >= FILL_WORD) ? ST_DRAIN : ST_ACCEPT;
            end
            default: begin
              state_s = ST_FLUSH;
            end
          endcase
        end else begin
          state_s = ST_ACCEPT;
        end
      end
      ST_ZEROS: begin
        if ((SUM_W'(fill_r) + SUM_W'(zeros_r)) >= SUM_WORD) begin
          // The rest of the top word is unary zeros: emit it and restart empty.
          wr_en_s   = 1'b1;
          wr_data_s = acc_r[ACC_W-1:WORD_W];
          zeros_s   = Q_W'(SUM_W'(zeros_r) + SUM_W'(fill_r) - SUM_WORD);
          fill_s    = FILL_ZERO;
          acc_s     = ACC_ZERO;
        end else begin
          app_len_s = FILL_W'(zeros_r) + FILL_ONE + FILL_W'(k_r);
          acc_s     = append_bits(acc_r, fill_r, code_val(low_r, k_r), app_len_s);
          fill_s    = fill_r + app_len_s;
          zeros_s   = Q_ZERO;
          state_s   = (fill_s >= FILL_WORD) ? ST_DRAIN : ST_ACCEPT;
        end
      end
      ST_DRAIN: begin
        if (fill_r >= FILL_WORD) begin
          wr_en_s   = 1'b1;
          wr_data_s = acc_r[ACC_W-1:WORD_W];
          acc_s     = acc_r << WORD_W;
          fill_s    = fill_r - FILL_WORD;
          state_s   = ST_ACCEPT;
        end else begin
          state_s = ST_ACCEPT;
        end
      end
      ST_FLUSH: begin
        if (fill_r != FILL_ZERO) begin
          // Emit the zero-padded partial word, then report on the next cycle.
          wr_en_s   = 1'b1;
          wr_data_s = acc_r[ACC_W-1:WORD_W];
          acc_s     = ACC_ZERO;
          fill_s    = FILL_ZERO;
          state_s   = ST_FLUSH;
        end else begin
          done_s  = 1'b1;
          state_s = ST_ACCEPT;
        end
      end
      default: begin
        state_s = ST_ACCEPT;
      end
    endcase
  end

  // State, datapath, address/count bookkeeping and registered outputs.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_r      <= ST_ACCEPT;
      acc_r        <= ACC_ZERO;
      fill_r       <= FILL_ZERO;
      zeros_r      <= Q_ZERO;
      k_r          <= {LEN_W{1'b0}};
      low_r        <= {(WORD_W-1){1'b0}};
      addr_r       <= ADDR_ZERO;
      count_r      <= CNT_ZERO;
      ready_r      <= 1'b1;
      ram_en_r     <= 1'b0;
      ram_addr_r   <= ADDR_ZERO;
      ram_data_r   <= WORD_ZERO;
      done_r       <= 1'b0;
      word_count_r <= CNT_ZERO;
    end else begin
      state_r    <= state_s;
      acc_r      <= acc_s;
      fill_r     <= fill_s;
      zeros_r    <= zeros_s;
      k_r        <= k_s;
      low_r      <= low_s;
      ready_r    <= (state_s == ST_ACCEPT);
      ram_en_r   <= wr_en_s;
      ram_data_r <= wr_data_s;
      done_r     <= done_s;
      if (wr_en_s) begin
        ram_addr_r <= addr_r;
        addr_r     <= addr_r + ADDR_ONE;
        if (count_r < CNT_MAX) begin
          count_r <= count_r + CNT_ONE;
        end
      end
      if (done_s) begin
        word_count_r <= count_r;
        addr_r       <= ADDR_ZERO;
        count_r      <= CNT_ZERO;
      end
    end
  end

endmodule

// File: tb/tb_rice_stream_packer.sv
// Directed and random-stream bench for rice_stream_packer (WORD_W=16, PARAM_W=5).
module tb_rice_stream_packer;

  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int PARAM_W = 5;
  localparam int Q_W     = 16;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iValid;
  logic        oReady;
  logic [1:0]  iKind;
  logic [15:0] iUpper;
  logic [14:0] iLower;
  logic [3:0]  iLen;
  logic [4:0]  iRiceParam;
  logic        oRamEnable;
  logic [15:0] oRamAddress;
  logic [15:0] oRamData;
  logic        oFlushDone;
  logic [16:0] oWordCount;

  always #5 iClock = ~iClock;

  rice_stream_packer #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .PARAM_W(PARAM_W), .Q_W(Q_W)
  ) dut (
    .iClock(iClock), .iReset(iReset), .iValid(iValid), .oReady(oReady),
    .iKind(iKind), .iUpper(iUpper), .iLower(iLower), .iLen(iLen),
    .iRiceParam(iRiceParam), .oRamEnable(oRamEnable), .oRamAddress(oRamAddress),
    .oRamData(oRamData), .oFlushDone(oFlushDone), .oWordCount(oWordCount)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] act_q[$];
  logic [31:0] exp_q[$];
  logic [16:0] done_q[$];
  logic [16:0] exp_done_q[$];
  bit          mq[$];
  logic [15:0] m_addr;
  logic [16:0] m_count;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Capture every RAM write and every flush report, once per output cycle.
  always @(negedge iClock) begin
    if (oRamEnable === 1'b1) act_q.push_back({oRamAddress, oRamData});
    if (oFlushDone === 1'b1) done_q.push_back(oWordCount);
  end

  // Reference packer: a plain bit queue cut into 16-bit words.
  task automatic m_bit(input bit b);
    logic [15:0] w;
    mq.push_back(b);
    if (mq.size() == 16) begin
      w = 16'h0000;
      for (int i = 0; i < 16; i++) w = {w[14:0], mq.pop_front()};
      exp_q.push_back({m_addr, w});
      m_addr++;
      m_count++;
    end
  endtask

  task automatic m_field(input logic [15:0] val, input int len);
    for (int i = len - 1; i >= 0; i--) m_bit(val[i]);
  endtask

  task automatic m_code(input int q, input int k, input logic [14:0] low);
    for (int i = 0; i < q; i++) m_bit(1'b0);
    m_bit(1'b1);
    for (int i = k - 1; i >= 0; i--) m_bit(low[i]);
  endtask

  task automatic m_flush();
    while (mq.size() != 0) m_bit(1'b0);
    exp_done_q.push_back(m_count);
    m_addr  = 16'h0000;
    m_count = 17'h00000;
  endtask

  // Present a command; while the DUT stalls, iValid stays high with junk fields.
  task automatic send(input logic [1:0] kind, input logic [15:0] q, input logic [14:0] low,
                      input logic [3:0] len, input logic [4:0] par);
    int waited;
    waited = 0;
    @(negedge iClock);
    while (oReady !== 1'b1 && waited < 200) begin
      iValid = 1'b1;
      iKind = 2'($urandom);
      iUpper = 16'($urandom);
      iLower = 15'($urandom);
      iLen = 4'($urandom);
      iRiceParam = 5'($urandom);
      @(negedge iClock);
      waited++;
    end
    if (oReady !== 1'b1) check_eq("ready_timeout", 64'(oReady), 64'd1);
    iValid = 1'b1;
    iKind = kind;
    iUpper = q;
    iLower = low;
    iLen = len;
    iRiceParam = par;
    @(posedge iClock);
    #1;
    iValid = 1'b0;
  endtask

  task automatic idle(input int n);
    iValid = 1'b0;
    repeat (n) @(negedge iClock);
  endtask

  task automatic expect_write(input string tag, input logic [15:0] a, input logic [15:0] d);
    int w;
    logic [31:0] e;
    w = 0;
    while (act_q.size() == 0 && w < 40) begin
      @(negedge iClock);
      w++;
    end
    if (act_q.size() == 0) begin
      check_eq({tag, "_present"}, 64'd0, 64'd1);
    end else begin
      e = act_q.pop_front();
      check_eq({tag, "_addr"}, 64'(e[31:16]), 64'(a));
      check_eq({tag, "_data"}, 64'(e[15:0]), 64'(d));
    end
  endtask

  task automatic expect_done(input string tag, input logic [16:0] cnt);
    int w;
    w = 0;
    while (done_q.size() == 0 && w < 40) begin
      @(negedge iClock);
      w++;
    end
    if (done_q.size() == 0) check_eq({tag, "_present"}, 64'd0, 64'd1);
    else check_eq(tag, 64'(done_q.pop_front()), 64'(cnt));
  endtask

  initial begin
    int r;
    int q;
    int k;
    int len;
    int idx;
    logic [14:0] low;
    logic [4:0]  par;

    iReset = 1'b1;
    iValid = 1'b0;
    iKind = 2'd0;
    iUpper = 16'h0000;
    iLower = 15'h0000;
    iLen = 4'd0;
    iRiceParam = 5'd0;
    repeat (3) @(posedge iClock);
    @(negedge iClock);
    check_eq("rst_ready", 64'(oReady), 64'd1);
    check_eq("rst_en", 64'(oRamEnable), 64'd0);
    check_eq("rst_addr", 64'(oRamAddress), 64'd0);
    check_eq("rst_data", 64'(oRamData), 64'd0);
    check_eq("rst_done", 64'(oFlushDone), 64'd0);
    check_eq("rst_count", 64'(oWordCount), 64'd0);
    iReset = 1'b0;

    // 001 101, then 000000000 1 -> 0011010000000001
    send(2'd0, 16'd2, 15'h0005, 4'd3, 5'd0);
    idle(3);
    check_eq("code1_no_write", 64'(act_q.size()), 64'd0);
    send(2'd0, 16'd9, 15'h0000, 4'd0, 5'd0);
    expect_write("code2", 16'd0, 16'h3401);

    // Flush with nothing pending: pulse one cycle after acceptance, count 1.
    send(2'd3, 16'd0, 15'h0000, 4'd0, 5'd0);
    @(negedge iClock);
    check_eq("flush_empty_early", 64'(oFlushDone), 64'd0);
    @(negedge iClock);
    check_eq("flush_empty_pulse", 64'(oFlushDone), 64'd1);
    check_eq("flush_empty_cnt", 64'(oWordCount), 64'd1);
    expect_done("flush_empty_q", 17'd1);
    check_eq("flush_empty_no_write", 64'(act_q.size()), 64'd0);

    // fill=5 (10110), then q=40 k=2 low=11: B000, 0000, 0007.
    send(2'd2, 16'd0, 15'h0016, 4'd5, 5'd0);
    send(2'd0, 16'd40, 15'h0003, 4'd2, 5'd0);
    @(negedge iClock);
    check_eq("long_ready_low", 64'(oReady), 64'd0);
    expect_write("long_w0", 16'd0, 16'hB000);
    expect_write("long_w1", 16'd1, 16'h0000);
    expect_write("long_w2", 16'd2, 16'h0007);

    // Header 11111 + raw 10110100101 = FDA5; code q=0 k=15 all ones = FFFF.
    send(2'd1, 16'd0, 15'h0000, 4'd0, 5'h1F);
    send(2'd2, 16'd0, 15'h05A5, 4'd11, 5'd0);
    send(2'd0, 16'd0, 15'h7FFF, 4'd15, 5'd0);
    expect_write("hdr_raw", 16'd3, 16'hFDA5);
    expect_write("code_k15", 16'd4, 16'hFFFF);

    // Partial flush of 101 -> A000 at addr 5, count 6, next frame at addr 0.
    send(2'd2, 16'd0, 15'h0005, 4'd3, 5'd0);
    send(2'd3, 16'd0, 15'h0000, 4'd0, 5'd0);
    expect_write("flush_pad", 16'd5, 16'hA000);
    expect_done("flush_count", 17'd6);
    send(2'd0, 16'd15, 15'h0000, 4'd0, 5'd0);
    expect_write("after_flush", 16'd0, 16'h0001);

    // Reset in the middle of a long unary run.
    send(2'd2, 16'd0, 15'h0001, 4'd1, 5'd0);
    send(2'd0, 16'd100, 15'h0000, 4'd0, 5'd0);
    @(negedge iClock);
    @(negedge iClock);
    iReset = 1'b1;
    @(negedge iClock);
    check_eq("midrst_en", 64'(oRamEnable), 64'd0);
    check_eq("midrst_ready", 64'(oReady), 64'd1);
    check_eq("midrst_addr", 64'(oRamAddress), 64'd0);
    iReset = 1'b0;
    expect_write("midrst_pre", 16'd1, 16'h8000);
    idle(6);
    check_eq("midrst_no_late_write", 64'(act_q.size()), 64'd0);
    send(2'd0, 16'd2, 15'h0005, 4'd3, 5'd0);
    send(2'd0, 16'd9, 15'h0000, 4'd0, 5'd0);
    expect_write("midrst_repack", 16'd0, 16'h3401);
    send(2'd3, 16'd0, 15'h0000, 4'd0, 5'd0);
    expect_done("midrst_flush_count", 17'd1);
    idle(4);
    check_eq("directed_no_extra_write", 64'(act_q.size()), 64'd0);
    check_eq("directed_no_extra_done", 64'(done_q.size()), 64'd0);

    // Random mixed stream against the bit-queue reference.
    act_q.delete();
    done_q.delete();
    m_addr = 16'h0000;
    m_count = 17'h00000;
    for (int n = 0; n < 1000; n++) begin
      r = $urandom_range(0, 99);
      low = 15'($urandom);
      if (r < 50) begin
        q = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 90) : $urandom_range(0, 18);
        k = $urandom_range(0, 15);
        m_code(q, k, low);
        send(2'd0, 16'(q), low, 4'(k), 5'd0);
      end else if (r < 72) begin
        par = 5'($urandom);
        m_field({11'h000, par}, 5);
        send(2'd1, 16'd0, 15'h0000, 4'd0, par);
      end else if (r < 97) begin
        len = $urandom_range(0, 15);
        m_field({1'b0, low}, len);
        send(2'd2, 16'd0, low, 4'(len), 5'd0);
      end else begin
        m_flush();
        send(2'd3, 16'd0, 15'h0000, 4'd0, 5'd0);
      end
    end
    m_flush();
    send(2'd3, 16'd0, 15'h0000, 4'd0, 5'd0);
    idle(60);
    check_eq("rnd_nwords", 64'(act_q.size()), 64'(exp_q.size()));
    idx = 0;
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      check_eq($sformatf("rnd_word%0d", idx), 64'(act_q.pop_front()), 64'(exp_q.pop_front()));
      idx++;
    end
    check_eq("rnd_nflush", 64'(done_q.size()), 64'(exp_done_q.size()));
    idx = 0;
    while (done_q.size() > 0 && exp_done_q.size() > 0) begin
      check_eq($sformatf("rnd_flush%0d", idx), 64'(done_q.pop_front()), 64'(exp_done_q.pop_front()));
      idx++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
